decode_ctrl_pipe: RTL and testbench
===================================

Name: decode_ctrl_pipe

Overview:
Pipelined successor of the combinational control decoder. Accepts instructions from fetch over a valid/ready handshake and decodes them into a packed control bundle. Registers the bundle into the ID/EX boundary. Adds load-use hazard bubbling, a multi-cycle MUL busy interlock, flush, illegal-instruction flagging and an optional M-extension.

Parameters:
XLEN, 32, instruction/data width; only 32 is supported.
EN_MEXT, 1, 1 = MUL decoded; 0 = MUL flagged illegal.
MUL_LATENCY, 3, multiplier cycles; range 1..15.

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock, synchronous, active-low
if_valid  in  1  fetch has an instruction
if_ready  out  1  decoder accepts this cycle
if_instr  in  XLEN  instruction word
flush  in  1  branch/jump redirect; kill in-flight decode
id_valid  out  1  id_ctrl/id_illegal are valid
id_ready  in  1  execute accepts the bundle
id_ctrl  out  CTRL_W  packed ctrl_t (pkg)
id_illegal  out  1  unsupported opcode/funct

Behaviour:
- ctrl_t fields, MSB first, CTRL_W=33: alu_op[4:0], alu_en, mul_en, immgen_en, rs1[4:0], rs2[4:0], rd[4:0], rd_we, rs_re[1:0], op2_imm, exec_sel[1:0], pcadd_merge, dmem_re, dmem_we, wb_sel.
- alu_op codes are unchanged from the existing decoder:
  - R-type: ADD1 SUB2 AND3 OR4 XOR5 SLT6 SLTU7 SRA8 SRL9 SLL10.
  - I-type: ADDI11 ANDI12 ORI13 XORI14 SLTI15 SLTIU16 SRAI17 SRLI18 SLLI19.
  - Other: LUI20 LOAD21 STORE22 BEQ23 BNE24 BLT25 BGE26 BLTU27 BGEU28 AUIPC29 JAL30 JALR31.
- Decode is exact. Any opcode/funct3/funct7 combination outside the list gives id_illegal=1 and id_ctrl=0. With EN_MEXT=0, MUL is illegal. Unused rs fields are 0.
- rd==0 forces rd_we=0. Reads of x0 never create hazards.
- Reset (rst_n=0 at clk edge): id_valid=0, id_ctrl=0, id_illegal=0, mul_cnt=0. if_ready=0 while rst_n=0.
- Handoff_in = if_valid & if_ready. Handoff_out = id_valid & id_ready.
- Latency: one cycle from handoff_in to id_valid=1 with the decoded bundle.
- stall = load_use | (mul_cnt != 0).
- load_use = id_valid & id_ctrl.dmem_re & (id_ctrl.rd != 0) & ((rs_re[0] & rs1 == id_ctrl.rd) | (rs_re[1] & rs2 == id_ctrl.rd)), with rs1/rs2/rs_re decoded from if_instr.
- if_ready = rst_n & !flush & !stall & (!id_valid | id_ready). Purely combinational; no combinational path from if_valid to if_ready.
- Output register update, in priority order:
  1. flush → id_valid<=0, mul_cnt<=0; the incoming instruction is dropped.
  2. handoff_in → load the new bundle, id_valid<=1.
  3. handoff_out without handoff_in → id_valid<=0 (bubble).
  4. otherwise → hold.
- While id_valid & !id_ready, id_ctrl and id_illegal are stable.
- Load-use gives exactly one bubble cycle. The load leaves, id_valid drops, and the dependent instruction is accepted on the following cycle.
- MUL interlock: on handoff_out with id_ctrl.mul_en, mul_cnt <= MUL_LATENCY-1. Otherwise it decrements while nonzero. MUL_LATENCY=1 never stalls. Counter width is $clog2(MUL_LATENCY+1).
- Simultaneous flush and handoff_out: execute takes the bundle and the register clears. Flush does not retract a completed handoff.
- Illegal instructions pass through with no hazard and no writes. The trap is handled downstream.
- Reset mid-stall or mid-MUL clears all state. The first post-reset instruction is accepted with no bubble.

Decomposition:
- Package riscv_ctrl_pkg:
  - opcode constants (OP_R=7'h33, OP_I=7'h13, OP_LOAD=7'h03, OP_STORE=7'h23, OP_BR=7'h63, OP_JAL=7'h6F, OP_JALR=7'h67, OP_LUI=7'h37, OP_AUIPC=7'h17);
  - alu_op_e enum;
  - ctrl_t packed struct and CTRL_W.
- Sub-module instr_decoder (parameter EN_MEXT): purely combinational, instr → {ctrl_t, illegal}. decode_ctrl_pipe owns the handshake, hazard logic, counter and register.

Test Plan:
- Reset and ADD: rst_n low 2 cycles, then ADD x3,x1,x2 (0x002081B3), id_ready=1 → after reset id_valid=0 and id_ctrl=0; one cycle later id_valid=1, alu_op=1, rd=3, rd_we=1, rs_re=11, id_illegal=0.
- Load-use: LW x5,0(x1) then ADD x6,x5,x0 back-to-back, id_ready=1 → if_ready=0 for one cycle, one id_valid=0 bubble, ADD issued next cycle. Repeat with ADD x6,x0,x7 → no bubble.
- MUL interlock: MUL_LATENCY=3, MUL x4,x1,x2 then ADDI stream → mul_en=1 on the MUL; if_ready low exactly 2 cycles after its handoff. EN_MEXT=0 → MUL gives id_illegal=1, id_ctrl=0, no stall.
- Backpressure: id_ready=0 for 4 cycles with if_valid=1 → id_ctrl/id_illegal held constant, if_ready=0; resumes with no loss or duplication.
- Flush: flush=1 while id_valid=1 and mul_cnt=2 → next cycle id_valid=0, mul_cnt=0, the instruction offered that cycle is not accepted; the following instruction is accepted immediately.
- Edge cases:
  - ADDI x0,x0,0 (0x00000013) → rd_we=0.
  - Opcode 7'h7F → id_illegal=1.
  - SRAI funct7=0100000 → alu_op=17.
  - JALR → exec_sel=11, alu_op=31.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: opcodes, ALU op codes and the packed control bundle shared by the decode pipeline
package riscv_ctrl_pkg;
  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  typedef enum logic [4:0] {
    ALU_NOP   = 5'd0,
    ALU_ADD   = 5'd1,
    ALU_SUB   = 5'd2,
    ALU_AND   = 5'd3,
    ALU_OR    = 5'd4,
    ALU_XOR   = 5'd5,
    ALU_SLT   = 5'd6,
    ALU_SLTU  = 5'd7,
    ALU_SRA   = 5'd8,
    ALU_SRL   = 5'd9,
    ALU_SLL   = 5'd10,
    ALU_ADDI  = 5'd11,
    ALU_ANDI  = 5'd12,
    ALU_ORI   = 5'd13,
    ALU_XORI  = 5'd14,
    ALU_SLTI  = 5'd15,
    ALU_SLTIU = 5'd16,
    ALU_SRAI  = 5'd17,
    ALU_SRLI  = 5'd18,
    ALU_SLLI  = 5'd19,
    ALU_LUI   = 5'd20,
    ALU_LOAD  = 5'd21,
    ALU_STORE = 5'd22,
    ALU_BEQ   = 5'd23,
    ALU_BNE   = 5'd24,
    ALU_BLT   = 5'd25,
    ALU_BGE   = 5'd26,
    ALU_BLTU  = 5'd27,
    ALU_BGEU  = 5'd28,
    ALU_AUIPC = 5'd29,
    ALU_JAL   = 5'd30,
    ALU_JALR  = 5'd31
  } alu_op_e;
  typedef struct packed {
    alu_op_e     alu_op;
    logic        alu_en;
    logic        mul_en;
    logic        immgen_en;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic [1:0]  rs_re;
    logic        op2_imm;
    logic [1:0]  exec_sel;
    logic        pcadd_merge;
    logic        dmem_re;
    logic        dmem_we;
    logic        wb_sel;
  } ctrl_t;
  localparam int CTRL_W = $bits(ctrl_t);
endpackage

// File: rtl/decode_ctrl_pipe_instr_decoder.sv
// instr_decoder: exact combinational decode of one instruction word into a control bundle plus illegal flag
module instr_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter bit EN_MEXT = 1'b1
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [1:0] rr;
  logic       wr, ok;
  ctrl_t      c;
  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  always_comb begin
    c = '0;
    ok = 1'b1;
    rr = 2'b00;
    wr = 1'b0;
    c.alu_en = 1'b1;
    c.immgen_en = 1'b1;
    c.op2_imm = 1'b1;
    case (opc)
      OP_R: begin
        rr = 2'b11;
        wr = 1'b1;
        c.immgen_en = 1'b0;
        c.op2_imm = 1'b0;
        case ({f7, f3})
          {7'h00, 3'd0}: c.alu_op = ALU_ADD;
          {7'h20, 3'd0}: c.alu_op = ALU_SUB;
          {7'h00, 3'd7}: c.alu_op = ALU_AND;
          {7'h00, 3'd6}: c.alu_op = ALU_OR;
          {7'h00, 3'd4}: c.alu_op = ALU_XOR;
          {7'h00, 3'd2}: c.alu_op = ALU_SLT;
          {7'h00, 3'd3}: c.alu_op = ALU_SLTU;
          {7'h20, 3'd5}: c.alu_op = ALU_SRA;
          {7'h00, 3'd5}: c.alu_op = ALU_SRL;
          {7'h00, 3'd1}: c.alu_op = ALU_SLL;
          {7'h01, 3'd0}: begin
            c.alu_en = 1'b0;
            c.mul_en = 1'b1;
            ok = EN_MEXT;
          end
          default: ok = 1'b0;
        endcase
      end
      OP_I: begin
        rr = 2'b01;
        wr = 1'b1;
        case (f3)
          3'd0: c.alu_op = ALU_ADDI;
          3'd7: c.alu_op = ALU_ANDI;
          3'd6: c.alu_op = ALU_ORI;
          3'd4: c.alu_op = ALU_XORI;
          3'd2: c.alu_op = ALU_SLTI;
          3'd3: c.alu_op = ALU_SLTIU;
          3'd1: begin
            c.alu_op = ALU_SLLI;
            ok = f7 == 7'h00;
          end
          default: begin
            c.alu_op = f7[5] ? ALU_SRAI : ALU_SRLI;
            ok = (f7 & 7'h5F) == 7'h00;
          end
        endcase
      end
      OP_LOAD: begin
        rr = 2'b01;
        wr = 1'b1;
        c.alu_op = ALU_LOAD;
        c.dmem_re = 1'b1;
        c.wb_sel = 1'b1;
        ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      end
      OP_STORE: begin
        rr = 2'b11;
        c.alu_op = ALU_STORE;
        c.dmem_we = 1'b1;
        ok = f3 < 3'd3;
      end
      OP_BR: begin
        rr = 2'b11;
        c.op2_imm = 1'b0;
        c.exec_sel = 2'b01;
        case (f3)
          3'd0: c.alu_op = ALU_BEQ;
          3'd1: c.alu_op = ALU_BNE;
          3'd4: c.alu_op = ALU_BLT;
          3'd5: c.alu_op = ALU_BGE;
          3'd6: c.alu_op = ALU_BLTU;
          3'd7: c.alu_op = ALU_BGEU;
          default: ok = 1'b0;
        endcase
      end
      OP_JAL: begin
        wr = 1'b1;
        c.alu_op = ALU_JAL;
        c.exec_sel = 2'b10;
        c.pcadd_merge = 1'b1;
      end
      OP_JALR: begin
        rr = 2'b01;
        wr = 1'b1;
        c.alu_op = ALU_JALR;
        c.exec_sel = 2'b11;
        c.pcadd_merge = 1'b1;
        ok = f3 == 3'd0;
      end
      OP_LUI: begin
        wr = 1'b1;
        c.alu_op = ALU_LUI;
      end
      OP_AUIPC: begin
        wr = 1'b1;
        c.alu_op = ALU_AUIPC;
        c.pcadd_merge = 1'b1;
      end
      default: ok = 1'b0;
    endcase
    c.rs_re = rr;
    c.rs1 = rr[0] ? instr[19:15] : 5'd0;
    c.rs2 = rr[1] ? instr[24:20] : 5'd0;
    c.rd = wr ? instr[11:7] : 5'd0;
    c.rd_we = wr & |instr[11:7];
  end
  assign ctrl = ok ? c : '0;
  assign illegal = !ok;
endmodule

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: handshake decode stage registering the control bundle into ID/EX with load-use, MUL and flush interlocks
module decode_ctrl_pipe
  import riscv_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit EN_MEXT     = 1'b1,
  parameter int MUL_LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [XLEN-1:0]   if_instr,
  input  logic              flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [CTRL_W-1:0] id_ctrl,
  output logic              id_illegal
);
  localparam int CW = $clog2(MUL_LATENCY + 1);
  ctrl_t         dec, id_q;
  logic          dec_ill, load_use, stall, hin, hout;
  logic [CW-1:0] mul_cnt;
  instr_decoder #(.EN_MEXT(EN_MEXT)) u_dec (
    .instr  (if_instr),
    .ctrl   (dec),
    .illegal(dec_ill)
  );
  assign load_use = id_valid & id_q.dmem_re & (id_q.rd != 5'd0) &
                    ((dec.rs_re[0] & (dec.rs1 == id_q.rd)) | (dec.rs_re[1] & (dec.rs2 == id_q.rd)));
  assign stall    = load_use | (mul_cnt != '0);
  assign if_ready = rst_n & !flush & !stall & (!id_valid | id_ready);
  assign hin      = if_valid & if_ready;
  assign hout     = id_valid & id_ready;
  assign id_ctrl  = id_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_q <= '0;
      id_illegal <= 1'b0;
      mul_cnt <= '0;
    end else begin
      id_valid <= flush ? 1'b0 : hin ? 1'b1 : hout ? 1'b0 : id_valid;
      if (hin) begin
        id_q <= dec;
        id_illegal <= dec_ill;
      end
      mul_cnt <= flush ? '0 :
                 (hout & id_q.mul_en) ? CW'(MUL_LATENCY - 1) :
                 (mul_cnt != '0) ? mul_cnt - CW'(1) : mul_cnt;
    end
  end
endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb_decode_ctrl_pipe: randomized and directed checks of the decode pipeline against a behavioural model
module tb_decode_ctrl_pipe;
  import riscv_ctrl_pkg::*;
  localparam int LAT = 3;
  logic clk = 1'b0, rst_n, if_valid, if_ready, flush, id_valid, id_ready, id_illegal;
  logic [31:0] if_instr;
  logic [CTRL_W-1:0] id_ctrl, c0;
  logic r0, v0, il0;
  ctrl_t dq, dq0;
  int n_chk = 0, n_fail = 0, cyc = 0, busy_until = -1;
  bit m_valid = 0, m_ill = 0, s_rdy, s_vld, s0_rdy;
  ctrl_t m_ctrl = '0;
  assign dq = id_ctrl;
  assign dq0 = c0;
  always #5 clk = ~clk;
  decode_ctrl_pipe #(.XLEN(32), .EN_MEXT(1'b1), .MUL_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .flush(flush), .id_valid(id_valid), .id_ready(id_ready), .id_ctrl(id_ctrl), .id_illegal(id_illegal)
  );
  decode_ctrl_pipe #(.XLEN(32), .EN_MEXT(1'b0), .MUL_LATENCY(LAT)) dut0 (
    .clk(clk), .rst_n(rst_n), .if_valid(1'b1), .if_ready(r0), .if_instr(if_instr),
    .flush(1'b0), .id_valid(v0), .id_ready(1'b1), .id_ctrl(c0), .id_illegal(il0)
  );
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  function automatic void mdec(input logic [31:0] i, input bit mext, output ctrl_t c, output bit ill);
    int rt0[8] = '{1, 10, 6, 7, 5, 9, 4, 3};
    int it[8]  = '{11, 19, 15, 16, 14, 18, 13, 12};
    int bt[8]  = '{23, 24, -1, -1, 25, 26, 27, 28};
    logic [6:0] op, f7;
    logic [2:0] f3;
    int a;
    bit r1, r2, wr, mul;
    op = i[6:0]; f7 = i[31:25]; f3 = i[14:12];
    a = -1; r1 = 0; r2 = 0; wr = 0; mul = 0;
    if (op == 7'h33) begin
      r1 = 1; r2 = 1; wr = 1;
      if (f7 == 7'h00) a = rt0[f3];
      else if (f7 == 7'h20 && f3 == 0) a = 2;
      else if (f7 == 7'h20 && f3 == 5) a = 8;
      else if (f7 == 7'h01 && f3 == 0 && mext) begin a = 0; mul = 1; end
    end else if (op == 7'h13) begin
      r1 = 1; wr = 1;
      if (f3 == 1) a = (f7 == 0) ? 19 : -1;
      else if (f3 == 5) a = (f7 == 0) ? 18 : (f7 == 7'h20) ? 17 : -1;
      else a = it[f3];
    end else if (op == 7'h03) begin
      r1 = 1; wr = 1;
      if (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) a = 21;
    end else if (op == 7'h23) begin
      r1 = 1; r2 = 1;
      if (f3 < 3) a = 22;
    end else if (op == 7'h63) begin
      r1 = 1; r2 = 1; a = bt[f3];
    end else if (op == 7'h6F) begin
      wr = 1; a = 30;
    end else if (op == 7'h67) begin
      r1 = 1; wr = 1;
      if (f3 == 0) a = 31;
    end else if (op == 7'h37) begin
      wr = 1; a = 20;
    end else if (op == 7'h17) begin
      wr = 1; a = 29;
    end
    c = '0;
    ill = (a < 0);
    if (!ill) begin
      c.alu_op = alu_op_e'(a[4:0]);
      c.alu_en = !mul;
      c.mul_en = mul;
      c.immgen_en = (op != 7'h33);
      c.op2_imm = (op != 7'h33) && (op != 7'h63);
      c.rs1 = r1 ? i[19:15] : 5'd0;
      c.rs2 = r2 ? i[24:20] : 5'd0;
      c.rd = wr ? i[11:7] : 5'd0;
      c.rd_we = wr && (i[11:7] != 0);
      c.rs_re = {r2, r1};
      c.exec_sel = (op == 7'h63) ? 2'd1 : (op == 7'h6F) ? 2'd2 : (op == 7'h67) ? 2'd3 : 2'd0;
      c.pcadd_merge = (op == 7'h17) || (op == 7'h6F) || (op == 7'h67);
      c.dmem_re = (op == 7'h03);
      c.dmem_we = (op == 7'h23);
      c.wb_sel = (op == 7'h03);
    end
  endfunction
  task automatic step();
    ctrl_t dc;
    bit di, lu, rdy, hin, hout;
    @(negedge clk);
    mdec(if_instr, 1'b1, dc, di);
    lu = m_valid && m_ctrl.dmem_re && m_ctrl.rd != 0 &&
         ((dc.rs_re[0] && dc.rs1 == m_ctrl.rd) || (dc.rs_re[1] && dc.rs2 == m_ctrl.rd));
    rdy = rst_n && !flush && !lu && cyc > busy_until && (!m_valid || id_ready);
    s_rdy = if_ready; s_vld = id_valid; s0_rdy = r0;
    chk("if_ready", if_ready, rdy);
    chk("id_valid", id_valid, m_valid);
    if (m_valid) begin
      chk("id_ctrl", id_ctrl, m_ctrl);
      chk("id_illegal", id_illegal, m_ill);
    end
    hin = if_valid && rdy;
    hout = m_valid && id_ready;
    if (!rst_n) begin
      m_valid = 0; m_ctrl = '0; m_ill = 0; busy_until = -1;
    end else begin
      if (hout && m_ctrl.mul_en) busy_until = cyc + LAT - 1;
      if (flush) begin m_valid = 0; busy_until = cyc; end
      else if (hin) begin m_valid = 1; m_ctrl = dc; m_ill = di; end
      else if (hout) m_valid = 0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] rnd_instr();
    logic [4:0] rd, r1, r2;
    logic [2:0] f3;
    logic [11:0] imm;
    logic [6:0] f7;
    rd = 5'($urandom_range(0, 7)); r1 = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7));
    f3 = 3'($urandom); imm = 12'($urandom);
    f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    case ($urandom_range(0, 11))
      0:  return {f7, r2, r1, f3, rd, 7'h33};
      1:  return {7'h01, r2, r1, 3'd0, rd, 7'h33};
      2:  return {imm, r1, f3, rd, 7'h13};
      3:  return {f7, r2, r1, $urandom_range(0, 1) ? 3'd1 : 3'd5, rd, 7'h13};
      4:  return {imm, r1, f3, rd, 7'h03};
      5:  return {imm[11:5], r2, r1, f3, imm[4:0], 7'h23};
      6:  return {imm[11:5], r2, r1, f3, imm[4:0], 7'h63};
      7:  return {imm, r1, f3, rd, 7'h6F};
      8:  return {imm, r1, f3, rd, 7'h67};
      9:  return {imm, r1, f3, rd, $urandom_range(0, 1) ? 7'h37 : 7'h17};
      10: return {7'($urandom), r2, r1, f3, rd, 7'h33};
      default: return $urandom;
    endcase
  endfunction
  initial begin
    ctrl_t pc, held;
    bit pi, hill;
    int lows, lows0;
    mdec(32'h002081B3, 1'b1, pc, pi);
    chk("model_add_op", pc.alu_op, 1);
    chk("model_add_rd", pc.rd, 3);
    chk("model_add_rsre", pc.rs_re, 2'b11);
    mdec(32'h02208233, 1'b0, pc, pi);
    chk("model_mul_nomext_ill", pi, 1);
    rst_n = 0; if_valid = 0; id_ready = 1; flush = 0; if_instr = 32'h0;
    step(); step();
    chk("rst_valid", id_valid, 0);
    chk("rst_ctrl", id_ctrl, 0);
    chk("rst_ill", id_illegal, 0);
    rst_n = 1; if_valid = 1; if_instr = 32'h002081B3;
    step();
    chk("add_valid", id_valid, 1);
    chk("add_op", dq.alu_op, 1);
    chk("add_rd", dq.rd, 3);
    chk("add_we", dq.rd_we, 1);
    chk("add_rsre", dq.rs_re, 2'b11);
    chk("add_ill", id_illegal, 0);
    if_instr = 32'h0000A283;
    step();
    if_instr = 32'h00028333;
    step();
    chk("lu_stall", s_rdy, 0);
    step();
    chk("lu_bubble", s_vld, 0);
    chk("lu_accept", s_rdy, 1);
    chk("lu_add_rd", dq.rd, 6);
    if_instr = 32'h0000A283;
    step();
    if_instr = 32'h00700333;
    step();
    chk("nolu_rdy", s_rdy, 1);
    if_instr = 32'h02208233;
    step();
    chk("mul_en", dq.mul_en, 1);
    chk("mext0_ill", il0, 1);
    chk("mext0_ctrl", c0, 0);
    if_instr = 32'h00108093;
    step();
    chk("mul_leave_rdy", s_rdy, 1);
    lows = 0; lows0 = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      lows += !s_rdy;
      lows0 += !s0_rdy;
    end
    chk("mul_stall_cycles", lows, 2);
    chk("mext0_no_stall", lows0, 0);
    id_ready = 0;
    step();
    held = dq; hill = id_illegal;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("bp_rdy", s_rdy, 0);
      chk("bp_ctrl_held", dq, held);
      chk("bp_ill_held", id_illegal, hill);
    end
    id_ready = 1;
    if_instr = 32'h02208233;
    step(); step();
    if_instr = 32'h00108093;
    step();
    flush = 1; if_instr = 32'h00208113;
    step();
    chk("flush_rdy", s_rdy, 0);
    chk("flush_valid", id_valid, 0);
    flush = 0; if_instr = 32'h00500193;
    step();
    chk("post_flush_rdy", s_rdy, 1);
    chk("post_flush_rd", dq.rd, 3);
    if_instr = 32'h00000013;
    step();
    chk("addi_x0_we", dq.rd_we, 0);
    if_instr = 32'h0000007F;
    step();
    chk("op7f_ill", id_illegal, 1);
    chk("op7f_ctrl", id_ctrl, 0);
    if_instr = 32'h4030D113;
    step();
    chk("srai_op", dq.alu_op, 17);
    if_instr = 32'h000100E7;
    step();
    chk("jalr_exec", dq.exec_sel, 2'b11);
    chk("jalr_op", dq.alu_op, 31);
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      if_valid = ($urandom_range(0, 3) != 0);
      id_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      if_instr = rnd_instr();
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
